// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state type and SPI mode/width constants for the receive path
package spi_pkg;
  typedef enum logic {SPI_IDLE, SPI_SHIFT} spi_state_e;
  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;
  localparam int SPI_DATA_W = 8;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular receive buffer with registered head, occupancy count and overflow pulse
module sync_fifo
  import spi_pkg::*;
#(
  parameter int DATA_W     = SPI_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [DATA_W-1:0]             wdata,
  input  logic                          pop,
  output logic [DATA_W-1:0]             rdata,
  output logic                          valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic overflow_q, overflow_d;
  logic empty, full, do_push, do_pop;
  // a pop frees the slot a same-cycle push needs when full; pops on empty are ignored
  always_comb begin
    empty = count_q == '0;
    full = count_q == CW'(FIFO_DEPTH);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    overflow_d = push && !do_push;
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = wdata;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end
  // storage, pointers and status registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
    end
  end
  assign rdata = mem_q[rd_ptr_q];
  assign valid = !empty;
  assign count = count_q;
  assign overflow = overflow_q;
endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampling mode-0 SPI slave receiver with FIFO; SPI_RX_LSB_FIRST_EN selects LSB-first shifting
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sclk,
  input  logic                          mosi,
  input  logic                          cs_n,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err
);
  localparam int BW = $clog2(DATA_W);
  logic [SYNC_STAGES-1:0] sclk_s_q, sclk_s_d, mosi_s_q, mosi_s_d, cs_s_q, cs_s_d;
  logic sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
  logic sclk_rise_q, sclk_rise_d, cs_rise_q, cs_rise_d;
  logic sclk_sync, mosi_sync, cs_sync;
  spi_state_e state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d, shifted;
  logic push_q, push_d, frame_err_q, frame_err_d;
  assign sclk_sync = sclk_s_q[SYNC_STAGES-1];
  assign mosi_sync = mosi_s_q[SYNC_STAGES-1];
  assign cs_sync = cs_s_q[SYNC_STAGES-1];
`ifdef SPI_RX_LSB_FIRST_EN
  assign shifted = {mosi_sync, shift_q[DATA_W-1:1]};
`else
  assign shifted = {shift_q[DATA_W-2:0], mosi_sync};
`endif
  // synchronizer chains and registered rise detectors
  always_comb begin
    sclk_s_d = {sclk_s_q[SYNC_STAGES-2:0], sclk};
    mosi_s_d = {mosi_s_q[SYNC_STAGES-2:0], mosi};
    cs_s_d = {cs_s_q[SYNC_STAGES-2:0], cs_n};
    sclk_prev_d = sclk_sync;
    cs_prev_d = cs_sync;
    sclk_rise_d = sclk_sync && !sclk_prev_q;
    cs_rise_d = cs_sync && !cs_prev_q;
  end
  // pin conditioning registers; idle levels are sclk low, cs_n high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_s_q <= '0;
      mosi_s_q <= '0;
      cs_s_q <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q <= 1'b1;
      sclk_rise_q <= 1'b0;
      cs_rise_q <= 1'b0;
    end else begin
      sclk_s_q <= sclk_s_d;
      mosi_s_q <= mosi_s_d;
      cs_s_q <= cs_s_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q <= cs_prev_d;
      sclk_rise_q <= sclk_rise_d;
      cs_rise_q <= cs_rise_d;
    end
  end
  // frame FSM: shift on sclk rises, push full words, flag partial words at deselect
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    shift_d = shift_q;
    push_d = 1'b0;
    frame_err_d = 1'b0;
    if (state_q == SPI_IDLE) begin
      cnt_d = '0;
      shift_d = '0;
      state_d = cs_sync ? SPI_IDLE : SPI_SHIFT;
    end else if (cs_rise_q) begin
      frame_err_d = cnt_q != '0;
      cnt_d = '0;
      shift_d = '0;
      state_d = SPI_IDLE;
    end else if (sclk_rise_q) begin
      shift_d = shifted;
      push_d = cnt_q == BW'(DATA_W - 1);
      cnt_d = push_d ? '0 : cnt_q + 1'b1;
    end
  end
  // FSM state, bit counter, shift register and registered pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SPI_IDLE;
      cnt_q <= '0;
      shift_q <= '0;
      push_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      push_q <= push_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign frame_err = frame_err_q;
  sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push_q),
    .wdata(shift_q),
    .pop(rx_ready),
    .rdata(rx_data),
    .valid(rx_valid),
    .count(fifo_count),
    .overflow(overflow)
  );
endmodule
